seq_inv: RTL
============

Name: seq_inv

Overview:
- Inverse pair-reorder stage for the NTT ALU datapath.
- Accepts a two-lane coefficient stream and buffers one block of 2S beats, where S = 2^LOG_S.
- Emits the block either unchanged or transposed. The transpose undoes the stride-S lane interleave applied on the forward path, feeding butterfly results back into bank write order.
- Ping-pong buffering with valid/ready on both sides sustains one pair per cycle.

Parameters:
- logq, 17: coefficient width in bits.
- LOG_S, 0: log2 of stride S. Block length is 2S beats; LOG_S = 0 gives 2x2 transpose.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_v  input  1  input pair valid.
- in_ready  output  1  input pair accepted when in_v & in_ready.
- in0  input  logq  lane-0 coefficient.
- in1  input  logq  lane-1 coefficient.
- mode  input  1  0 = pass-through order, 1 = transpose; sampled on the first beat of each block.
- out_v  output  1  output pair valid.
- out_ready  input  1  downstream accepts pair when out_v & out_ready.
- out0  output  logq  lane-0 result.
- out1  output  logq  lane-1 result.
- busy  output  1  high while any bank holds or is collecting data.

Behaviour:
- Storage: two banks, each holding 2S pairs as arrays A[0..2S-1] (lane 0) and B[0..2S-1] (lane 1). Each bank also has a full flag and a latched mode bit. Data arrays are not reset.
- Write side: wr_bank, wr_cnt (0..2S-1).
  - in_ready = !full[wr_bank] & !rst.
  - On accept: A[wr_cnt] <= in0, B[wr_cnt] <= in1. If wr_cnt == 0, bank mode <= mode.
  - wr_cnt increments on each accept. At wr_cnt == 2S-1 it wraps to 0, full[wr_bank] is set and wr_bank toggles.
- Read side: rd_bank, rd_cnt j (0..2S-1).
  - out_v = full[rd_bank].
  - On out_v & out_ready, j increments. At j == 2S-1 it wraps, full[rd_bank] is cleared and rd_bank toggles.
- Output mapping, combinational from rd_bank and j:
  - mode 0: (out0, out1) = (A[j], B[j]).
  - mode 1, j < S: (A[j], A[S+j]).
  - mode 1, j >= S: (B[j-S], B[j]).
  - out0 and out1 are 0 whenever out_v = 0.
- Latency: out_v rises the cycle after the 2S-th beat of a block is accepted. There is no combinational in->out path.
- Throughput: with out_ready held high, one pair per cycle sustained indefinitely, with no bubbles between blocks.
- Full/stall:
  - When both banks are full, in_ready = 0.
  - A read-side bank release and a write into the other bank can occur in the same cycle.
  - A bank freed in cycle t accepts writes from cycle t+1.
- Backpressure: while out_ready = 0, out0, out1, out_v and j hold stable.
- Mode: a change of mode mid-block is ignored; each block keeps its latched mode.
- busy = full[0] | full[1] | (wr_cnt != 0).
- Reset: takes effect at any point, including mid-block.
  - Clears wr_cnt, rd_cnt, wr_bank, rd_bank, full[1:0] and the mode latches.
  - Partial and unread blocks are discarded.
  - During rst: out_v = 0, in_ready = 0, busy = 0, out0 = out1 = 0.
  - In the first cycle after rst deasserts: in_ready = 1.

Test Plan:
- LOG_S=0, mode=1: inputs (1,2),(3,4), out_ready=1 -> out_v rises the cycle after the second accept; outputs (1,3),(2,4).
- LOG_S=1, mode=1: inputs (a0,b0)..(a3,b3) = (10,20),(11,21),(12,22),(13,23) -> outputs (10,12),(11,13),(20,22),(21,23).
- LOG_S=1, mode=0: same inputs -> outputs identical to inputs in order. Then continuous streaming of 8 blocks with out_ready=1 -> in_ready stays 1 and out_v shows no gaps after the first block.
- Backpressure, LOG_S=0: out_ready=0 while writing 3 blocks -> in_ready drops after the 4th accepted beat (both banks full). Release out_ready -> 4 pairs drain in order, then the third block is accepted.
- Mode latch: mode=1 on beat 0 and toggled to 0 on beat 1 (LOG_S=0) -> block still emitted transposed.
- Mid-block reset: accept 1 beat, assert rst for 1 cycle -> out_v=0, busy=0, in_ready=1 after reset. The next full block emits only new data.

Source files
------------

// File: rtl/seq_inv_if.sv
// seq_inv_if: two-lane coefficient stream bundle for the inverse pair-reorder
// stage. Carries the upstream (in_*) and downstream (out_*) valid/ready
// handshakes of one seq_inv instance.
//   master : the side that feeds pairs in and accepts reordered pairs
//            (drives in_v/in0/in1/mode/out_ready)
//   slave  : the reorder stage itself
//            (drives in_ready/out_v/out0/out1)
interface seq_inv_if #(
  parameter int logq = 17
);
  logic            in_v;
  logic            in_ready;
  logic [logq-1:0] in0;
  logic [logq-1:0] in1;
  logic            mode;
  logic            out_v;
  logic            out_ready;
  logic [logq-1:0] out0;
  logic [logq-1:0] out1;

  modport master (
    output in_v, in0, in1, mode, out_ready,
    input  in_ready, out_v, out0, out1
  );

  modport slave (
    input  in_v, in0, in1, mode, out_ready,
    output in_ready, out_v, out0, out1
  );
endinterface

// File: rtl/seq_inv.sv
// seq_inv: inverse pair-reorder stage for the NTT ALU datapath.
// Collects blocks of 2S coefficient pairs (S = 2^LOG_S) into one of two
// ping-pong banks and replays each block either unchanged (mode 0) or
// transposed (mode 1), undoing the forward-path stride-S lane interleave.
// With out_ready held high the stage sustains one pair per cycle.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset; discards any partial/unread block
//   bus   - seq_inv_if.slave: in_v/in_ready/in0/in1/mode upstream,
//           out_v/out_ready/out0/out1 downstream
//   busy  - high while any bank is full or a block is being collected
module seq_inv #(
  parameter int logq  = 17,
  parameter int LOG_S = 0
) (
  input  logic        clk,
  input  logic        rst,
  seq_inv_if.slave    bus,
  output logic        busy
);

  localparam int S  = 1 << LOG_S;
  localparam int N  = 2 * S;
  localparam int CW = LOG_S + 1;

  localparam logic [CW-1:0] S_IDX = CW'(S);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);

  logic [logq-1:0] a_mem [2][N];
  logic [logq-1:0] b_mem [2][N];

  logic [1:0]      full;
  logic [1:0]      bank_mode;
  logic            wr_bank;
  logic            rd_bank;
  logic [CW-1:0]   wr_cnt;
  logic [CW-1:0]   rd_cnt;

  logic            wr_fire;
  logic            rd_fire;
  logic [logq-1:0] out0_c;
  logic [logq-1:0] out1_c;

  // Handshakes are masked by rst so nothing is offered or accepted while
  // the registers are being cleared.
  assign bus.in_ready = !full[wr_bank] && !rst;
  assign bus.out_v    = full[rd_bank] && !rst;
  assign wr_fire      = bus.in_v && bus.in_ready;
  assign rd_fire      = bus.out_v && bus.out_ready;
  assign busy         = !rst && ((|full) || (wr_cnt != '0));

  // Coefficient storage carries no reset; the full flags alone decide
  // whether a bank's contents are meaningful.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      a_mem[wr_bank][wr_cnt] <= bus.in0;
      b_mem[wr_bank][wr_cnt] <= bus.in1;
    end
  end

  // Write and read pointers. A write can only set the flag of a bank that
  // is currently empty and a read can only clear the flag of a bank that
  // is currently full, so the two updates never target the same bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      full      <= '0;
      bank_mode <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_cnt == '0) begin
          bank_mode[wr_bank] <= bus.mode;
        end
        if (wr_cnt == LAST) begin
          wr_cnt        <= '0;
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_cnt == LAST) begin
          rd_cnt        <= '0;
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Output mapping. In transpose mode the first half of the block pairs
  // lane-0 words j and S+j, the second half pairs lane-1 words j-S and j.
  always_comb begin
    out0_c = '0;
    out1_c = '0;
    if (bus.out_v) begin
      if (!bank_mode[rd_bank]) begin
        out0_c = a_mem[rd_bank][rd_cnt];
        out1_c = b_mem[rd_bank][rd_cnt];
      end else if (rd_cnt < S_IDX) begin
        out0_c = a_mem[rd_bank][rd_cnt];
        out1_c = a_mem[rd_bank][rd_cnt + S_IDX];
      end else begin
        out0_c = b_mem[rd_bank][rd_cnt - S_IDX];
        out1_c = b_mem[rd_bank][rd_cnt];
      end
    end
  end

  assign bus.out0 = out0_c;
  assign bus.out1 = out1_c;

endmodule
